bf_sequencer: RTL

Parametrised Brainfuck execution sequencer: the next generation of the processor control FSM, with the PC, data pointer, depth counter and temp register folded in. It adds variable-latency memory handshaking, `.`/`,` byte I/O over valid/ready, halt on NUL, and bracket-scan error detection. Program and tape share one memory port; the block sits between that memory and the chip I/O pins.

---
 rtl/bf_sequencer.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/bf_sequencer.sv
// bf_sequencer: Brainfuck execution sequencer with shared program/tape memory port.
// Holds pc, data pointer, bracket depth and temp register; memory, output and
// input transfers all use variable-latency handshakes.
// Optional feature macro: BF_IO_EN enables the `.` and `,` byte streams.
// Without it, those two bytes decode as non-instructions and the stream ports are idle.
module bf_sequencer #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int DEPTH_W   = 4,
  parameter int DATA_BASE = 2**(ADDR_W-1)
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              en,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              halted,
  output logic              error
);

  localparam logic [7:0] C_INC   = 8'h2B;  // +
  localparam logic [7:0] C_DEC   = 8'h2D;  // -
  localparam logic [7:0] C_RIGHT = 8'h3E;  // >
  localparam logic [7:0] C_LEFT  = 8'h3C;  // <
  localparam logic [7:0] C_OPEN  = 8'h5B;  // [
  localparam logic [7:0] C_CLOSE = 8'h5D;  // ]
`ifdef BF_IO_EN
  localparam logic [7:0] C_OUT   = 8'h2E;  // .
  localparam logic [7:0] C_IN    = 8'h2C;  // ,
`endif

  localparam logic [ADDR_W-1:0]  A_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0]  A_MAX  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0]  A_BASE = ADDR_W'(DATA_BASE);
  localparam logic [DATA_W-1:0]  D_ONE  = DATA_W'(1);
  localparam logic [DEPTH_W-1:0] K_ONE  = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] K_MAX  = {DEPTH_W{1'b1}};

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_RD,
    S_EXEC,
    S_WR,
    S_SCAN,
`ifdef BF_IO_EN
    S_OUT,
    S_IN,
`endif
    S_HALT
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   pc_q, dp_q;
  logic [DATA_W-1:0]   temp_q;
  logic [DEPTH_W-1:0]  depth_q;
  logic [7:0]          instr_q;
  logic                dir_q;    // 0 = forward scan, 1 = backward scan
  logic                error_q;

  // Scan bookkeeping for the character arriving on mem_rdata this cycle
  logic [7:0]          scan_ch;
  logic                depth_up, depth_dn, scan_match, depth_ovf;
  logic [DEPTH_W-1:0]  depth_d;
  logic [ADDR_W-1:0]   scan_pc_d;
  logic                scan_pc_err;
  logic [ADDR_W-1:0]   cell_addr;

  assign cell_addr = A_BASE + dp_q;
  assign scan_ch   = mem_rdata[7:0];

  // Opening/closing roles swap with scan direction
  always_comb begin
    depth_up    = dir_q ? (scan_ch == C_CLOSE) : (scan_ch == C_OPEN);
    depth_dn    = dir_q ? (scan_ch == C_OPEN)  : (scan_ch == C_CLOSE);
    depth_ovf   = depth_up && (depth_q == K_MAX);
    scan_match  = depth_dn && (depth_q == K_ONE);
    depth_d     = depth_q;
    if (depth_up) depth_d = depth_q + K_ONE;
    if (depth_dn) depth_d = depth_q - K_ONE;
    // On the match the pc always steps forward, past the matching bracket
    if (scan_match) begin
      scan_pc_d   = pc_q + A_ONE;
      scan_pc_err = (pc_q == A_MAX);
    end else if (dir_q) begin
      scan_pc_d   = pc_q - A_ONE;
      scan_pc_err = (pc_q == '0);
    end else begin
      scan_pc_d   = pc_q + A_ONE;
      scan_pc_err = (pc_q == A_MAX);
    end
  end

  // Control FSM plus datapath registers; en=0 freezes everything
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      dp_q    <= '0;
      temp_q  <= '0;
      depth_q <= '0;
      instr_q <= '0;
      dir_q   <= 1'b0;
      error_q <= 1'b0;
    end else if (en) begin
      case (state_q)
        S_FETCH: begin
          if (mem_ack) begin
            instr_q <= mem_rdata[7:0];
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (instr_q)
            C_RIGHT: begin
              dp_q    <= dp_q + A_ONE;
              pc_q    <= pc_q + A_ONE;
              state_q <= S_FETCH;
            end
            C_LEFT: begin
              dp_q    <= dp_q - A_ONE;
              pc_q    <= pc_q + A_ONE;
              state_q <= S_FETCH;
            end
            C_INC, C_DEC, C_OPEN, C_CLOSE: state_q <= S_RD;
`ifdef BF_IO_EN
            C_OUT:   state_q <= S_RD;
            C_IN:    state_q <= S_IN;
`endif
            8'h00:   state_q <= S_HALT;
            default: begin
              pc_q    <= pc_q + A_ONE;
              state_q <= S_FETCH;
            end
          endcase
        end
        S_RD: begin
          if (mem_ack) begin
            temp_q  <= mem_rdata;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (instr_q)
            C_INC: begin
              temp_q  <= temp_q + D_ONE;
              state_q <= S_WR;
            end
            C_DEC: begin
              temp_q  <= temp_q - D_ONE;
              state_q <= S_WR;
            end
`ifdef BF_IO_EN
            C_OUT:   state_q <= S_OUT;
`endif
            C_OPEN: begin
              pc_q <= pc_q + A_ONE;
              if (temp_q == '0) begin
                depth_q <= K_ONE;
                dir_q   <= 1'b0;
                state_q <= S_SCAN;
              end else begin
                state_q <= S_FETCH;
              end
            end
            C_CLOSE: begin
              if (temp_q != '0) begin
                pc_q    <= pc_q - A_ONE;
                depth_q <= K_ONE;
                dir_q   <= 1'b1;
                state_q <= S_SCAN;
              end else begin
                pc_q    <= pc_q + A_ONE;
                state_q <= S_FETCH;
              end
            end
            default: begin
              pc_q    <= pc_q + A_ONE;
              state_q <= S_FETCH;
            end
          endcase
        end
        S_WR: begin
          if (mem_ack) begin
            pc_q    <= pc_q + A_ONE;
            state_q <= S_FETCH;
          end
        end
`ifdef BF_IO_EN
        S_OUT: begin
          if (out_ready) begin
            pc_q    <= pc_q + A_ONE;
            state_q <= S_FETCH;
          end
        end
        S_IN: begin
          if (in_valid) begin
            temp_q  <= in_data;
            state_q <= S_WR;
          end
        end
`endif
        S_SCAN: begin
          if (mem_ack) begin
            if (depth_ovf || scan_pc_err) begin
              error_q <= 1'b1;
              state_q <= S_HALT;
            end else begin
              depth_q <= depth_d;
              pc_q    <= scan_pc_d;
              state_q <= scan_match ? S_FETCH : S_SCAN;
            end
          end
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_HALT;
      endcase
    end
  end

  // Moore outputs decoded from state and registers
  assign mem_req   = en && (state_q == S_FETCH || state_q == S_RD ||
                            state_q == S_WR    || state_q == S_SCAN);
  assign mem_we    = (state_q == S_WR);
  assign mem_addr  = (state_q == S_RD || state_q == S_WR) ? cell_addr : pc_q;
  assign mem_wdata = temp_q;
  assign halted    = (state_q == S_HALT);
  assign error     = error_q;

`ifdef BF_IO_EN
  assign out_valid = en && (state_q == S_OUT);
  assign out_data  = temp_q;
  assign in_ready  = en && (state_q == S_IN);
`else
  // Stream ports idle; inputs deliberately left unconsumed
  logic unused_io;
  assign unused_io = ^{out_ready, in_valid, in_data};
  assign out_valid = 1'b0;
  assign out_data  = '0;
  assign in_ready  = 1'b0;
`endif

endmodule
